game_referee: RTL and testbench

Round sequencer that drives the game-side inputs of `game_logic`: it generates the red/green light phases with pseudo-random durations, gates play through `enable`, and declares `win` or loss from `position` and `status_code`. It sits beside `game_logic` in the top level. It consumes that block's outputs and produces its `red`, `win` and `enable` inputs, which closes the play loop.

---
 rtl/game_pkg.sv | 34 +++
 rtl/lfsr8.sv | 20 ++
 rtl/game_referee.sv | 117 +++++++++++
 tb/tb_game_referee.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game types: phase encodings, status codes, LFSR constants and phase-length helper.
// Latency: n/a (package only).
// Backpressure: n/a.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GREEN = 3'd1,
        RED   = 3'd2,
        WON   = 3'd3,
        LOST  = 3'd4
    } phase_t;

    localparam logic [3:0] STATUS_PLAYING = 4'd0;

    localparam int                LFSR_W    = 8;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
    endfunction

    // Counter load value (length - 1) for the phase being entered.
    function automatic logic [4:0] phase_load(input logic [LFSR_W-1:0] v,
                                              input logic              to_green,
                                              input logic [4:0]        gmin,
                                              input logic [4:0]        rmin);
        if (to_green)
            return gmin + {2'b00, v[2:0]} - 5'd1;
        else
            return rmin + {3'b000, v[1:0]} - 5'd1;
    endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR that advances one position per step pulse.
// Latency: new value visible the cycle after step.
// Backpressure: none; holds its value while step is low.
module lfsr8 import game_pkg::*; #(
    parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step,
    output logic [LFSR_W-1:0] value
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            value <= SEED;
        else if (step)
            value <= lfsr_next(value);
    end

endmodule

// File: rtl/game_referee.sv
// Round sequencer: random red/green phases, play enable, win/loss verdict; REFEREE_TIMEOUT_EN adds a round time limit.
// Latency: all outputs registered, one cycle after the causing input.
// Backpressure: none; tick is ignored outside GREEN/RED and start is ignored during play.
module game_referee import game_pkg::*; #(
    parameter logic [7:0] LFSR_SEED     = 8'hA5,
    parameter int         GREEN_MIN     = 4,
    parameter int         RED_MIN       = 2,
    parameter int         TIMEOUT_TICKS = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic [3:0] position,
    input  logic [3:0] max_steps,
    input  logic [3:0] status_code,
    output logic       red,
    output logic       win,
    output logic       lost,
    output logic       enable,
    output logic [2:0] phase
);

    localparam logic [4:0] GMIN = 5'(GREEN_MIN);
    localparam logic [4:0] RMIN = 5'(RED_MIN);

    phase_t      state;
    phase_t      nxt;
    logic [4:0]  cnt;
    logic [4:0]  cnt_nxt;
    logic        step;
    logic [7:0]  lfsr_val;
    logic        playing;
    logic        timeout_hit;

    assign playing = (state == GREEN) || (state == RED);

    lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .step  (step),
        .value (lfsr_val)
    );

`ifdef REFEREE_TIMEOUT_EN
    logic [8:0] round_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            round_cnt <= 9'd0;
        else if (!playing && start)
            round_cnt <= 9'd0;
        else if (playing && tick)
            round_cnt <= round_cnt + 9'd1;
    end

    // Fires on the tick that brings the round count up to the limit.
    assign timeout_hit = playing && tick && (round_cnt == 9'(TIMEOUT_TICKS - 1));
`else
    assign timeout_hit = (TIMEOUT_TICKS < 0);
`endif

    always_comb begin
        nxt     = state;
        cnt_nxt = cnt;
        step    = 1'b0;
        unique case (state)
            IDLE, WON, LOST: begin
                if (start) begin
                    nxt     = GREEN;
                    cnt_nxt = phase_load(lfsr_val, 1'b1, GMIN, RMIN);
                    step    = 1'b1;
                end
            end
            GREEN, RED: begin
                if (status_code != STATUS_PLAYING) begin
                    nxt = LOST;
                end else if ((position == max_steps) && (max_steps != 4'd0)) begin
                    nxt = WON;
                end else if (timeout_hit) begin
                    nxt = LOST;
                end else if (tick) begin
                    if (cnt == 5'd0) begin
                        nxt     = (state == GREEN) ? RED : GREEN;
                        cnt_nxt = phase_load(lfsr_val, state == RED, GMIN, RMIN);
                        step    = 1'b1;
                    end else begin
                        cnt_nxt = cnt - 5'd1;
                    end
                end
            end
            default: nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= 5'd0;
            red    <= 1'b0;
            win    <= 1'b0;
            lost   <= 1'b0;
            enable <= 1'b0;
            phase  <= IDLE;
        end else begin
            state  <= nxt;
            cnt    <= cnt_nxt;
            red    <= (nxt == RED);
            win    <= (nxt == WON);
            lost   <= (nxt == LOST);
            enable <= (nxt == GREEN) || (nxt == RED);
            phase  <= nxt;
        end
    end

endmodule

// File: tb/tb_game_referee.sv
// Scoreboard bench for game_referee: expected output changes (with tick counts) are queued by stimulus,
// and a monitor pops one entry each time the DUT outputs change.
module tb_game_referee;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b1;
    logic       start = 1'b0;
    logic [3:0] position = 4'd0;
    logic [3:0] max_steps = 4'd14;
    logic [3:0] status_code = 4'd0;
    logic       red;
    logic       win;
    logic       lost;
    logic       enable;
    logic [2:0] phase;

    game_referee dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .start       (start),
        .position    (position),
        .max_steps   (max_steps),
        .status_code (status_code),
        .red         (red),
        .win         (win),
        .lost        (lost),
        .enable      (enable),
        .phase       (phase)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] vec;
        int         ticks;
        string      name;
    } exp_t;

    exp_t       q[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         tick_acc = 0;
    logic [6:0] prev = 7'h7F;
    bit         tick_rand = 1'b0;
    logic [7:0] m_lfsr = 8'hA5;
    int         last_len = 0;

    // {red, win, lost, enable, phase} required for a given phase code
    function automatic logic [6:0] vec_of(input logic [2:0] ph);
        return {ph == 3'd2, ph == 3'd3, ph == 3'd4, (ph == 3'd1) || (ph == 3'd2), ph};
    endfunction

    task automatic push(input string name, input logic [2:0] ph, input int ticks);
        exp_t e;
        e.vec   = vec_of(ph);
        e.ticks = ticks;
        e.name  = name;
        q.push_back(e);
    endtask

    // Queue entry into GREEN/RED; prev_ticks = -2 takes the previous phase length from the model.
    task automatic push_enter(input string name, input logic [2:0] ph, input int prev_ticks, output int used);
        int len;
        if (ph == 3'd1)
            len = 4 + int'(m_lfsr[2:0]);
        else
            len = 2 + int'(m_lfsr[1:0]);
        m_lfsr   = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        used     = (prev_ticks == -2) ? last_len : prev_ticks;
        push(name, ph, used);
        last_len = len;
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_drain(input string name, input int limit);
        int k;
        k = 0;
        while (q.size() != 0 && k < limit) begin
            cyc();
            k++;
        end
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: got %0d pending output changes after %0d cycles, required 0",
                     name, q.size(), limit);
            q.delete();
        end
    endtask

    initial forever begin
        @(posedge clk);
        #2;
        tick = tick_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    initial forever begin
        @(posedge clk);
        if (tick) tick_acc++;
    end

    initial forever begin
        logic [6:0] cur;
        exp_t       e;
        @(negedge clk);
        cur = {red, win, lost, enable, phase};
        if (cur !== prev) begin
            prev = cur;
            n_checks++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_change: got vec=%b, required no change", cur);
            end else begin
                e = q.pop_front();
                if (cur !== e.vec || (e.ticks >= 0 && tick_acc != e.ticks)) begin
                    n_fail++;
                    $display("FAIL %s: got vec=%b ticks=%0d, required vec=%b ticks=%0d",
                             e.name, cur, tick_acc, e.vec, e.ticks);
                end
            end
            tick_acc = 0;
        end
    end

    initial begin
        int         u;
        int         total;
        logic [2:0] ph;

        push("reset_state", 3'd0, -1);
        #1 rst = 1'b0;
        repeat (3) cyc();
        rst = 1'b1;
        repeat (2) cyc();

        // first round, then reset while RED
        push_enter("green_pre_reset", 3'd1, -1, u);
        push_enter("red_pre_reset", 3'd2, 9, u);
        start = 1'b1; cyc(); start = 1'b0;
        wait_drain("pre_reset", 40);
        cyc();
        push("reset_mid_red", 3'd0, -1);
        m_lfsr = 8'hA5;
        rst = 1'b0;
        repeat (2) cyc();
        rst = 1'b1;
        cyc();

        // start coincides with tick; lengths 9 / 4 / 9 from A5, 4A, 95
        push_enter("green_after_reset", 3'd1, -1, u);
        push_enter("green_len9", 3'd2, 9, u);
        push_enter("red_len4", 3'd1, 4, u);
        push_enter("green2_len9", 3'd2, 9, u);
        start = 1'b1; cyc(); start = 1'b0;
        wait_drain("seq", 60);

        push("caught_in_red", 3'd4, -1);
        status_code = 4'd1; cyc(); status_code = 4'd0;
        repeat (4) cyc();

        push_enter("restart_after_loss", 3'd1, -1, u);
        start = 1'b1; cyc(); start = 1'b0;
        wait_drain("restart_loss", 10);
        push("lost_beats_win", 3'd4, -1);
        status_code = 4'd1; position = 4'd14; cyc();
        status_code = 4'd0; position = 4'd0;
        repeat (3) cyc();

        push_enter("start_win_round", 3'd1, -1, u);
        start = 1'b1; cyc(); start = 1'b0;
        wait_drain("win_round", 10);
        push("win_in_green", 3'd3, -1);
        position = 4'd14;
        repeat (5) cyc();

        // start held in WON, no reseed; ticks now irregular
        tick_rand = 1'b1;
        push_enter("restart_from_won", 3'd1, -1, u);
        push_enter("restart_green_len", 3'd2, -2, u);
        start = 1'b1; position = 4'd0;
        wait_drain("restart_won", 200);
        start = 1'b0;

        // max_steps = 0 with position = 0 never wins; phases alternate for 1000+ ticks
        max_steps = 4'd0;
        position  = 4'd0;
        total = 0;
        ph = 3'd1;
        while (total < 1000) begin
            push_enter("alternate", ph, -2, u);
            total += u;
            ph = (ph == 3'd1) ? 3'd2 : 3'd1;
        end
        wait_drain("alternate", 5000);

        push("win_after_alternate", 3'd3, -1);
        max_steps = 4'd3;
        position  = 4'd3;
        wait_drain("win_after_alternate", 10);
        repeat (3) cyc();

        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL final_queue: got %0d pending, required 0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
